genius_control: RTL and testbench
=================================

GENIUS_CONTROL -- requirements
Module: genius_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- R  in  1  reset; synchronous, active-high.
REQ-002 Inputs SHALL be:
- enter  in  1  user start/confirm button; active-high, already synchronized, level signal.
- end_FPGA  in  1  FPGA sequence display finished.
- end_User  in  1  user entered full round sequence.
- end_time  in  1  play timer expired.
- win  in  1  final round reached.
- match  in  1  user sequence equals FPGA sequence.
REQ-003 Outputs SHALL be:
- R1  out  1  game-level clear (setup, round).
- R2  out  1  round-level clear (timer, user, FPGA counters and registers).
- E1  out  1  setup load enable.
- E2  out  1  timer/user-input enable.
- E3  out  1  FPGA sequence enable.
- E4  out  1  round counter increment.
- SEL  out  1  display select; 0 = game screen, 1 = result screen.
- state  out  3  current state code, for debug.

Function
REQ-004 The controller SHALL be a Moore FSM; outputs SHALL be decoded from the state register only.
REQ-005 State codes SHALL be: INIT=0, SETUP=1, SEQUENCE=2, PLAY=3, CHECK=4, NEXT_ROUND=5, RESULT=6.
REQ-006 Code 7 SHALL transition to INIT on the next clock, with all outputs 0.
REQ-007 The controller SHALL register enter each cycle.
REQ-008 enter_rise SHALL be defined as enter=1 AND registered enter=0, giving one pulse per press; holding enter SHALL NOT retrigger.
REQ-009 Transitions SHALL be:
- INIT -> SETUP unconditionally.
- SETUP -> SEQUENCE on enter_rise.
- SEQUENCE -> PLAY on end_FPGA.
- PLAY -> RESULT on end_time.
- PLAY -> CHECK on end_User with end_time=0.
- CHECK -> NEXT_ROUND if match=1 and win=0.
- CHECK -> RESULT if match=0 or win=1.
- NEXT_ROUND -> SEQUENCE unconditionally.
- RESULT -> INIT on enter_rise.
- Otherwise, hold state.
REQ-010 Output decode SHALL be as follows; any output not listed for a state SHALL be 0:
- INIT: R1=1, R2=1.
- SETUP: E1=1.
- SEQUENCE: E3=1.
- PLAY: E2=1.
- CHECK: none.
- NEXT_ROUND: E4=1, R2=1.
- RESULT: SEL=1.
REQ-011 If end_time and end_User are both 1 in PLAY in the same cycle, end_time SHALL take priority (-> RESULT).
REQ-012 In PLAY, end_FPGA, win and match SHALL be ignored.
REQ-013 In CHECK, end_time SHALL be ignored.
REQ-014 Exactly one cycle SHALL be spent in each of INIT, CHECK and NEXT_ROUND; E4 and the R2 pulse in NEXT_ROUND are therefore exactly one cycle wide.
REQ-015 Outputs SHALL change in the cycle after the state register updates, i.e. one clock after the qualifying input is sampled.
REQ-016 state SHALL equal the state register code.

Reset
REQ-017 While R=1 at a rising edge, the block SHALL load state=INIT and registered enter=0; R SHALL override every transition.
REQ-018 After R is released, the first cycle SHALL show INIT outputs: R1=1, R2=1, all others 0, state=0.
REQ-019 Asserting R mid-game (any state) SHALL return the block to INIT on that same edge; no E* output SHALL remain asserted after that edge.
REQ-020 An enter level already high when R is released SHALL NOT produce enter_rise in SETUP until enter is released and pressed again.

Verification
REQ-021 Nominal win: R pulse, then enter_rise in SETUP, then end_FPGA, then end_User with match=1 and win=1 -> state sequence 0,1,2,3,4,6 and SEL=1 in RESULT.
REQ-022 Round advance: CHECK with match=1, win=0 -> one cycle of NEXT_ROUND with E4=1 and R2=1, then SEQUENCE with E3=1.
REQ-023 Mismatch and timeout: CHECK with match=0 -> RESULT; PLAY with end_time=1 and end_User=1 in the same cycle -> RESULT, CHECK never entered.
REQ-024 Edge detect: enter held high for 10 cycles in SETUP -> exactly one transition; RESULT with enter still held -> stays in RESULT until release and a new press.
REQ-025 Reset mid-PLAY: R=1 in PLAY -> state=0 next cycle with R1=1, R2=1, E2=0; then SETUP one cycle later.
REQ-026 Illegal state: force state code 7 -> INIT next cycle, all outputs 0 while in code 7.

Source files
------------

// File: rtl/genius_control.sv
// genius_control
// Moore state machine that sequences one memory-game session: setup, FPGA
// sequence display, user play, check, round advance and result screen.
//
// Ports
//   CLOCK_50  in   system clock, rising-edge active
//   R         in   synchronous active-high reset
//   enter     in   start/confirm button level (already synchronized)
//   end_FPGA  in   FPGA sequence display finished
//   end_User  in   user entered the full round sequence
//   end_time  in   play timer expired
//   win       in   final round reached
//   match     in   user sequence equals FPGA sequence
//   R1        out  game-level clear (setup, round)
//   R2        out  round-level clear (timer, user, FPGA counters/registers)
//   E1        out  setup load enable
//   E2        out  timer/user-input enable
//   E3        out  FPGA sequence enable
//   E4        out  round counter increment
//   SEL       out  display select: 0 = game screen, 1 = result screen
//   state     out  current state code (debug)
module genius_control (
  input  logic       CLOCK_50,
  input  logic       R,
  input  logic       enter,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    SETUP      = 3'd1,
    SEQUENCE   = 3'd2,
    PLAY       = 3'd3,
    CHECK      = 3'd4,
    NEXT_ROUND = 3'd5,
    RESULT     = 3'd6
  } state_t;

  // Kept as a plain 3-bit vector so the unused code 7 is representable and
  // recovers through the default branch.
  logic [2:0] state_q;
  logic       enter_q;
  logic       enter_rise;

  // One pulse per press: a held button never retriggers.
  assign enter_rise = enter & ~enter_q;

  always_ff @(posedge CLOCK_50) begin
    if (R) begin
      state_q <= INIT;
      enter_q <= 1'b0;
    end else begin
      enter_q <= enter;
      case (state_q)
        INIT:       state_q <= SETUP;
        SETUP:      if (enter_rise) state_q <= SEQUENCE;
        SEQUENCE:   if (end_FPGA) state_q <= PLAY;
        PLAY: begin
          // Timer expiry wins over a simultaneous end of user entry.
          if (end_time)      state_q <= RESULT;
          else if (end_User) state_q <= CHECK;
        end
        CHECK: begin
          if (match && !win) state_q <= NEXT_ROUND;
          else               state_q <= RESULT;
        end
        NEXT_ROUND: state_q <= SEQUENCE;
        RESULT:     if (enter_rise) state_q <= INIT;
        default:    state_q <= INIT;
      endcase
    end
  end

  always_comb begin
    R1  = 1'b0;
    R2  = 1'b0;
    E1  = 1'b0;
    E2  = 1'b0;
    E3  = 1'b0;
    E4  = 1'b0;
    SEL = 1'b0;
    case (state_q)
      INIT: begin
        R1 = 1'b1;
        R2 = 1'b1;
      end
      SETUP:    E1 = 1'b1;
      SEQUENCE: E3 = 1'b1;
      PLAY:     E2 = 1'b1;
      NEXT_ROUND: begin
        E4 = 1'b1;
        R2 = 1'b1;
      end
      RESULT:   SEL = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_genius_control.sv
// tb_genius_control
// Self-checking bench for genius_control: directed game scenarios with
// literal expectations, then randomized stimulus compared every cycle against
// a transition-table model of the game rules.
module tb_genius_control;

  logic       CLOCK_50 = 1'b0;
  logic       R        = 1'b1;
  logic       enter    = 1'b0;
  logic       end_FPGA = 1'b0;
  logic       end_User = 1'b0;
  logic       end_time = 1'b0;
  logic       win      = 1'b0;
  logic       match    = 1'b0;
  logic       R1, R2, E1, E2, E3, E4, SEL;
  logic [2:0] state;
  logic [6:0] outs;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model state
  int unsigned m_state     = 0;
  bit          m_enter     = 1'b0;
  bit          model_valid = 1'b0;
  int unsigned inj_count   = 0;
  int unsigned inj_seen    = 0;

  // Expected {R1,R2,E1,E2,E3,E4,SEL} per state code 0..7
  localparam logic [6:0] OUT_TAB [8] = '{
    7'b1100000, 7'b0010000, 7'b0000100, 7'b0001000,
    7'b0000000, 7'b0100010, 7'b0000001, 7'b0000000
  };

  genius_control dut (
    .CLOCK_50 (CLOCK_50),
    .R        (R),
    .enter    (enter),
    .end_FPGA (end_FPGA),
    .end_User (end_User),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .R1       (R1),
    .R2       (R2),
    .E1       (E1),
    .E2       (E2),
    .E3       (E3),
    .E4       (E4),
    .SEL      (SEL),
    .state    (state)
  );

  assign outs = {R1, R2, E1, E2, E3, E4, SEL};

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // Game rules as a transition table on state codes.
  function automatic int unsigned model_next(input int unsigned cur, input bit rise,
                                             input bit ef, input bit eu, input bit et,
                                             input bit w, input bit m);
    case (cur)
      0:       return 1;
      1:       return rise ? 2 : 1;
      2:       return ef ? 3 : 2;
      3:       return et ? 6 : (eu ? 4 : 3);
      4:       return (m && !w) ? 5 : 6;
      5:       return 2;
      6:       return rise ? 0 : 6;
      default: return 0;
    endcase
  endfunction

  always @(posedge CLOCK_50) begin : model
    int unsigned cur;
    cur = (inj_count != inj_seen) ? 7 : m_state;
    inj_seen = inj_count;
    if (R) begin
      m_state     = 0;
      m_enter     = 1'b0;
      model_valid = 1'b1;
    end else begin
      m_state = model_next(cur, enter && !m_enter, end_FPGA, end_User, end_time, win, match);
      m_enter = enter;
    end
    #1;
    if (model_valid) begin
      check("model_state", state, m_state);
      check("model_outs", outs, OUT_TAB[m_state]);
    end
  end

  task automatic step(input string nm, input bit r, input bit en, input bit ef,
                      input bit eu, input bit et, input bit w, input bit m,
                      input int unsigned s);
    @(negedge CLOCK_50);
    R = r; enter = en; end_FPGA = ef; end_User = eu; end_time = et; win = w; match = m;
    @(posedge CLOCK_50);
    #2;
    check(nm, state, s);
  endtask

  task automatic inject_illegal();
    force dut.state_q = 3'd7;
    inj_count++;
    #1;
    check("illegal_state", state, 3'd7);
    check("illegal_outs", outs, 7'b0000000);
    #1;
    release dut.state_q;
  endtask

  initial begin
    // Reset and nominal win path
    step("rst", 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_outs", outs, 7'b1100000);
    step("setup", 0, 0, 0, 0, 0, 0, 0, 1);
    check("setup_outs", outs, 7'b0010000);
    step("start", 0, 1, 0, 0, 0, 0, 0, 2);
    check("seq_outs", outs, 7'b0000100);
    for (int i = 0; i < 9; i++) step("enter_held", 0, 1, 0, 0, 0, 0, 0, 2);
    step("play", 0, 1, 1, 0, 0, 0, 0, 3);
    check("play_outs", outs, 7'b0001000);
    step("play_ignore", 0, 0, 1, 0, 0, 1, 1, 3);
    step("check", 0, 0, 0, 1, 0, 0, 1, 4);
    check("check_outs", outs, 7'b0000000);
    // Round advance; end_time ignored in CHECK
    step("next_round", 0, 0, 0, 0, 1, 0, 1, 5);
    check("nr_outs", outs, 7'b0100010);
    step("seq_again", 0, 0, 0, 0, 0, 0, 0, 2);
    check("seq_again_outs", outs, 7'b0000100);
    step("play2", 0, 0, 1, 0, 0, 0, 0, 3);
    // Simultaneous timeout and end of entry
    step("timeout", 0, 0, 0, 1, 1, 0, 1, 6);
    check("result_outs", outs, 7'b0000001);
    step("res_rise", 0, 1, 0, 0, 0, 0, 0, 0);
    step("init_held", 0, 1, 0, 0, 0, 0, 0, 1);
    step("no_retrig", 0, 1, 0, 0, 0, 0, 0, 1);
    step("release", 0, 0, 0, 0, 0, 0, 0, 1);
    step("press", 0, 1, 0, 0, 0, 0, 0, 2);
    step("play3", 0, 1, 1, 0, 0, 0, 0, 3);
    step("win_check", 0, 1, 0, 1, 0, 1, 1, 4);
    step("win_result", 0, 1, 0, 0, 0, 1, 1, 6);
    check("win_sel", SEL, 1'b1);
    for (int i = 0; i < 3; i++) step("res_held", 0, 1, 0, 0, 0, 0, 0, 6);
    step("res_rel", 0, 0, 0, 0, 0, 0, 0, 6);
    step("res_press", 0, 1, 0, 0, 0, 0, 0, 0);
    step("s2", 0, 0, 0, 0, 0, 0, 0, 1);
    step("p2", 0, 1, 0, 0, 0, 0, 0, 2);
    step("pl4", 0, 0, 1, 0, 0, 0, 0, 3);
    // Mismatch
    step("mm_check", 0, 0, 0, 1, 0, 0, 0, 4);
    step("mm_result", 0, 0, 0, 0, 0, 0, 0, 6);
    step("mm_press", 0, 1, 0, 0, 0, 0, 0, 0);
    step("s3", 0, 0, 0, 0, 0, 0, 0, 1);
    step("p3", 0, 1, 0, 0, 0, 0, 0, 2);
    step("pl5", 0, 0, 1, 0, 0, 0, 0, 3);
    // Reset mid-PLAY
    step("mid_rst", 1, 0, 0, 0, 0, 0, 0, 0);
    check("mid_rst_outs", outs, 7'b1100000);
    step("after_rst", 0, 0, 0, 0, 0, 0, 0, 1);
    // Enter already high when reset releases
    step("rst_en", 1, 1, 0, 0, 0, 0, 0, 0);
    step("rel_en", 0, 1, 0, 0, 0, 0, 0, 1);
    step("rel_en_hold", 0, 1, 0, 0, 0, 0, 0, 1);
    step("rel_en_low", 0, 0, 0, 0, 0, 0, 0, 1);
    step("rel_en_press", 0, 1, 0, 0, 0, 0, 0, 2);
    // Illegal code recovery
    @(negedge CLOCK_50);
    inject_illegal();
    @(posedge CLOCK_50);
    #2;
    check("illegal_recover", state, 3'd0);
    check("illegal_recover_outs", outs, 7'b1100000);

    // Randomized phase, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLOCK_50);
      R        = ($urandom_range(63) == 0);
      if ($urandom_range(3) == 0) enter = ~enter;
      end_FPGA = ($urandom_range(3) == 0);
      end_User = ($urandom_range(3) == 0);
      end_time = ($urandom_range(5) == 0);
      win      = 1'($urandom_range(1));
      match    = ($urandom_range(2) != 0);
      if ($urandom_range(199) == 0) inject_illegal();
    end

    @(posedge CLOCK_50);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
